// File: rtl/booth_pkg.sv
// Shared types and constants for the booth operand feeder: FSM encoding,
// default operand width and the product-width helper.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int L_WORD_DEFAULT = 4;
  localparam int PROD_W_DEFAULT = 2 * L_WORD_DEFAULT;

  function automatic int prod_width(input int lw);
    return 2 * lw;
  endfunction

endpackage

// File: rtl/booth_operand_feeder_if.sv
// Bus bundle between the feeder, its operand producer, the booth multiplier
// and the result consumer. master = feeder side, slave = environment side.
interface booth_operand_feeder_if
  import booth_pkg::*;
#(
  parameter int l_word = L_WORD_DEFAULT
);
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid holds with stable data until then. mul_ready is a level, not a handshake.
  logic                  in_valid;
  logic                  in_ready;
  logic [l_word-1:0]     in_word1;
  logic [l_word-1:0]     in_word2;
  logic                  mul_start;
  logic [l_word-1:0]     mul_word1;
  logic [l_word-1:0]     mul_word2;
  logic                  mul_ready;
  logic [2*l_word-1:0]   mul_product;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*l_word-1:0]   res_product;

  modport master (
    input  in_valid, in_word1, in_word2, mul_ready, mul_product, res_ready,
    output in_ready, mul_start, mul_word1, mul_word2, res_valid, res_product
  );

  modport slave (
    output in_valid, in_word1, in_word2, mul_ready, mul_product, res_ready,
    input  in_ready, mul_start, mul_word1, mul_word2, res_valid, res_product
  );

endinterface

// File: rtl/booth_operand_fifo.sv
// Small synchronous FIFO holding packed operand pairs. Registered storage,
// head readable combinationally; a push into an empty FIFO shows next cycle.
module booth_operand_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/booth_operand_feeder.sv
// Issue stage in front of booth_multiplier: buffers operand pairs, issues one at a
// time and holds the product in a result slot. Optional: BOOTH_ZERO_BYPASS_EN.
module booth_operand_feeder
  import booth_pkg::*;
#(
  parameter int l_word = L_WORD_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  booth_operand_feeder_if.master        bus,
  output logic                          busy,
  output state_t                        dbg_state
);

  localparam int PW = prod_width(l_word);

  state_t            state_q, state_d;
  logic [l_word-1:0] mul_word1_q, mul_word1_d;
  logic [l_word-1:0] mul_word2_q, mul_word2_d;
  logic [PW-1:0]     res_product_q, res_product_d;
  logic              res_valid_q, res_valid_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PW-1:0]     fifo_rdata;
  logic [l_word-1:0] head_word1, head_word2;

  assign fifo_push  = bus.in_valid && !fifo_full;
  assign head_word1 = fifo_rdata[PW-1:l_word];
  assign head_word2 = fifo_rdata[l_word-1:0];

  booth_operand_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({bus.in_word1, bus.in_word2}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The head is popped and latched on the IDLE->ISSUE edge, so during ISSUE the
  // operands and the start pulse reach the multiplier together.
  always_comb begin
    state_d       = state_q;
    mul_word1_d   = mul_word1_q;
    mul_word2_d   = mul_word2_q;
    res_product_d = res_product_q;
    res_valid_d   = res_valid_q;
    fifo_pop      = 1'b0;

    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !res_valid_q) begin
`ifdef BOOTH_ZERO_BYPASS_EN
          if (head_word1 == '0 || head_word2 == '0) begin
            fifo_pop      = 1'b1;
            res_product_d = '0;
            res_valid_d   = 1'b1;
          end else
`endif
          if (bus.mul_ready) begin
            fifo_pop    = 1'b1;
            mul_word1_d = head_word1;
            mul_word2_d = head_word2;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (!bus.mul_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (bus.mul_ready) begin
          res_product_d = bus.mul_product;
          res_valid_d   = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mul_word1_q   <= '0;
      mul_word2_q   <= '0;
      res_product_q <= '0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mul_word1_q   <= mul_word1_d;
      mul_word2_q   <= mul_word2_d;
      res_product_q <= res_product_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign bus.in_ready    = !fifo_full;
  assign bus.mul_start   = (state_q == ST_ISSUE);
  assign bus.mul_word1   = mul_word1_q;
  assign bus.mul_word2   = mul_word2_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = res_product_q;
  assign busy            = (state_q != ST_IDLE) || !fifo_empty;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_booth_operand_feeder.sv
// Directed bench for booth_operand_feeder (l_word=4, DEPTH=4) with a behavioural
// multiplier whose latency varies between 3 and 10 cycles.
module tb_booth_operand_feeder;
  import booth_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   busy;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;
  logic [7:0] exp_q[$];

  booth_operand_feeder_if #(.l_word(4)) bus();

  booth_operand_feeder #(.l_word(4), .DEPTH(4)) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural multiplier ----------------
  logic       mdl_ready = 1'b1;
  logic [7:0] mdl_prod  = 8'h00;
  logic [3:0] mdl_a = 4'h0, mdl_b = 4'h0;
  int         mdl_cnt = 0;
  int         start_cnt = 0, start_busy = 0, stab_err = 0;

  assign bus.mul_ready   = mdl_ready;
  assign bus.mul_product = mdl_prod;

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] ea, eb;
    ea = {{4{a[3]}}, a};
    eb = {{4{b[3]}}, b};
    return ea * eb;
  endfunction

  always @(posedge clk) begin
    if (bus.mul_start) begin
      start_cnt <= start_cnt + 1;
      if (!mdl_ready) start_busy <= start_busy + 1;
      mdl_ready <= 1'b0;
      mdl_a     <= bus.mul_word1;
      mdl_b     <= bus.mul_word2;
      mdl_cnt   <= $urandom_range(9, 2);
    end else if (!mdl_ready) begin
      if (mdl_cnt == 0) begin
        mdl_ready <= 1'b1;
        mdl_prod  <= smul(mdl_a, mdl_b);
        if (dbg_state == ST_WAIT_DONE && (bus.mul_word1 !== mdl_a || bus.mul_word2 !== mdl_b))
          stab_err <= stab_err + 1;
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_pair(input logic [3:0] a, input logic [3:0] b, output bit ok);
    bit rdy;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_word1 = a;
    bus.in_word2 = b;
    for (int n = 0; n < 200; n++) begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [7:0] p, output bit ok);
    ok = 1'b0;
    p  = 8'h00;
    for (int n = 0; n < 300; n++) begin
      if (bus.res_valid === 1'b1) begin
        ok = 1'b1;
        p  = bus.res_product;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic accept_result();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b want=0", bus.res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (bus.mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start got=%0b want=0", bus.mul_start); end
    total++; if (bus.res_product !== 8'h00) begin bad++; $display("FAIL reset_res_product got=%h want=00", bus.res_product); end
    total++; if ({bus.mul_word1, bus.mul_word2} !== 8'h00) begin bad++; $display("FAIL reset_mul_words got=%h want=00", {bus.mul_word1, bus.mul_word2}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] p;
    int s0;
    s0 = start_cnt;
    push_pair(4'h3, 4'h5, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_push_timeout got=0 want=1"); end
    total++; if (bus.mul_start !== 1'b0) begin bad++; $display("FAIL single_start_early got=%0b want=0", bus.mul_start); end
    @(posedge clk); #1;
    total++; if (bus.mul_start !== 1'b1) begin bad++; $display("FAIL single_start_t2 got=%0b want=1", bus.mul_start); end
    total++; if ({bus.mul_word1, bus.mul_word2} !== 8'h35) begin bad++; $display("FAIL single_mul_words got=%h want=35", {bus.mul_word1, bus.mul_word2}); end
    @(posedge clk); #1;
    total++; if (bus.mul_start !== 1'b0) begin bad++; $display("FAIL single_start_one_cycle got=%0b want=0", bus.mul_start); end
    wait_result(p, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_result_timeout got=0 want=1"); end
    total++; if (p !== 8'h0F) begin bad++; $display("FAIL single_product got=%h want=0f", p); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL single_res_hold got=%0b want=1", bus.res_valid); end
    accept_result();
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL single_res_clear got=%0b want=0", bus.res_valid); end
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL single_start_count got=%0d want=1", start_cnt - s0); end
  endtask

  task automatic test_signed();
    bit ok;
    logic [7:0] p, e;
    logic [7:0] ops[2];
    ops[0] = 8'hD2;
    ops[1] = 8'h88;
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'h40);
    for (int i = 0; i < 2; i++) begin
      push_pair(ops[i][7:4], ops[i][3:0], ok);
      total++; if (!ok) begin bad++; $display("FAIL signed_push_timeout[%0d] got=0 want=1", i); end
    end
    for (int i = 0; i < 2; i++) begin
      wait_result(p, ok);
      e = exp_q.pop_front();
      total++; if (!ok || p !== e) begin bad++; $display("FAIL signed_product[%0d] got=%h want=%h", i, p, e); end
      accept_result();
    end
  endtask

  task automatic test_fill();
    bit ok;
    logic [7:0] p, e;
    logic [7:0] ops[5];
    int s0;
    ops[0] = 8'h12; ops[1] = 8'h77; ops[2] = 8'hFF; ops[3] = 8'h78; ops[4] = 8'h63;
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h02); exp_q.push_back(8'h31); exp_q.push_back(8'h01);
    exp_q.push_back(8'hC8); exp_q.push_back(8'h12);
    push_pair(4'h2, 4'h3, ok);
    wait_result(p, ok);
    e = exp_q.pop_front();
    total++; if (!ok || p !== e) begin bad++; $display("FAIL fill_first_product got=%h want=%h", p, e); end
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      push_pair(ops[i][7:4], ops[i][3:0], ok);
      total++; if (!ok) begin bad++; $display("FAIL fill_push_timeout[%0d] got=0 want=1", i); end
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_in_ready got=%0b want=0", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_word1 = ops[4][7:4];
    bus.in_word2 = ops[4][3:0];
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fill_stays_full got=%0b want=0", bus.in_ready); end
    total++; if (start_cnt !== s0) begin bad++; $display("FAIL fill_no_issue got=%0d want=%0d", start_cnt, s0); end
    accept_result();
    push_pair(ops[4][7:4], ops[4][3:0], ok);
    total++; if (!ok) begin bad++; $display("FAIL fill_fifth_push got=0 want=1"); end
    for (int i = 0; i < 5; i++) begin
      wait_result(p, ok);
      e = exp_q.pop_front();
      total++; if (!ok || p !== e) begin bad++; $display("FAIL fill_order[%0d] got=%h want=%h", i, p, e); end
      accept_result();
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    logic [7:0] p;
    int s0;
    push_pair(4'h5, 4'h5, ok);
    push_pair(4'h4, 4'hE, ok);
    wait_result(p, ok);
    total++; if (!ok || p !== 8'h19) begin bad++; $display("FAIL bp_first_product got=%h want=19", p); end
    s0 = start_cnt;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.res_product !== 8'h19) stable = 1'b0;
    end
    total++; if (!stable) begin bad++; $display("FAIL bp_result_stable got=0 want=1"); end
    total++; if (start_cnt !== s0) begin bad++; $display("FAIL bp_no_second_start got=%0d want=%0d", start_cnt, s0); end
    accept_result();
    wait_result(p, ok);
    total++; if (!ok || p !== 8'hF8) begin bad++; $display("FAIL bp_second_product got=%h want=f8", p); end
    accept_result();
  endtask

  task automatic test_zero_operand();
    bit ok;
    logic [7:0] p;
    int s0;
    s0 = start_cnt;
    push_pair(4'h0, 4'h7, ok);
`ifdef BOOTH_ZERO_BYPASS_EN
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL zero_res_early got=%0b want=0", bus.res_valid); end
    @(posedge clk); #1;
    total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL zero_bypass_valid got=%0b want=1", bus.res_valid); end
    total++; if (bus.res_product !== 8'h00) begin bad++; $display("FAIL zero_bypass_product got=%h want=00", bus.res_product); end
    total++; if (start_cnt !== s0) begin bad++; $display("FAIL zero_bypass_no_start got=%0d want=%0d", start_cnt, s0); end
`else
    wait_result(p, ok);
    total++; if (!ok || p !== 8'h00) begin bad++; $display("FAIL zero_product got=%h want=00", p); end
    total++; if (start_cnt !== s0 + 1) begin bad++; $display("FAIL zero_start_count got=%0d want=%0d", start_cnt, s0 + 1); end
`endif
    accept_result();
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    int s0;
    s0 = start_cnt;
    push_pair(4'h3, 4'h3, ok);
    push_pair(4'h2, 4'h2, ok);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (dbg_state == ST_WAIT_DONE) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    total++; if (!found) begin bad++; $display("FAIL rmid_reach_wait_done got=0 want=1"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rmid_res_valid got=%0b want=0", bus.res_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rmid_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    for (int n = 0; n < 50; n++) begin
      if (bus.mul_ready === 1'b1) break;
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rmid_late_ready_result got=%0b want=0", bus.res_valid); end
    total++; if (start_cnt !== s0 + 1) begin bad++; $display("FAIL rmid_start_count got=%0d want=%0d", start_cnt, s0 + 1); end
  endtask

  task automatic test_monitors();
    total++; if (start_busy !== 0) begin bad++; $display("FAIL mon_start_while_busy got=%0d want=0", start_busy); end
    total++; if (stab_err !== 0) begin bad++; $display("FAIL mon_operand_stability got=%0d want=0", stab_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_word1  = 4'h0;
    bus.in_word2  = 4'h0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_signed();
    test_fill();
    test_backpressure();
    test_zero_operand();
    test_reset_mid();
    test_monitors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_operand_feeder.md
Name: booth_operand_feeder

Overview:
- Upstream issue stage for booth_multiplier.
- Accepts signed operand pairs on a valid/ready interface and buffers them in a small FIFO.
- Issues one pair at a time to the multiplier (word1/word2/start), tracks its ready level, and captures the product into a result register with its own valid/ready handshake.
- Decouples producers from the multiplier's variable, data-dependent latency.

Parameters:
- l_word, 4: operand width in bits; product width is 2*l_word.
- DEPTH, 4: operand FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clock rising edge.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_word1  in  l_word  multiplicand, two's complement.
- in_word2  in  l_word  multiplier, two's complement.
- mul_start  out  1  one-cycle issue pulse to the multiplier.
- mul_word1  out  l_word  registered operand to the multiplier; stable from issue until capture.
- mul_word2  out  l_word  registered operand to the multiplier; stable from issue until capture.
- mul_ready  in  1  multiplier level: 1 = idle/done, 0 = busy.
- mul_product  in  2*l_word  multiplier result; valid while mul_ready=1 after completion.
- res_valid  out  1  result register full.
- res_ready  in  1  consumer accepts the result.
- res_product  out  2*l_word  captured product.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (synchronous):
  - FIFO pointers and count cleared.
  - FSM to IDLE.
  - All outputs 0 except in_ready=1.
  - res_product=0; mul_word1/2=0.
  - Reset during any state aborts the operation: the in-flight pair and all FIFO contents are discarded, and no result is produced.
- FIFO:
  - Push when in_valid&&in_ready; pop on the ISSUE cycle.
  - Read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - When full, in_ready=0, including in a cycle where a pop occurs (no same-cycle push-through).
  - Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
  - Push when empty: data is visible at the head next cycle; no bypass.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - IDLE -> ISSUE when FIFO not empty, res_valid=0, and mul_ready=1.
  - ISSUE (one cycle):
    - Latch the FIFO head into mul_word1/2 and pop.
    - mul_start=1 during the cycle after the latch, i.e. start and the operands arrive together.
    - Go to WAIT_ACK.
  - WAIT_ACK: stay while mul_ready=1; -> WAIT_DONE when mul_ready=0.
  - WAIT_DONE: when mul_ready=1, capture res_product<=mul_product, set res_valid=1, -> IDLE.
  - mul_start is asserted for exactly one cycle per operation and never in any other state.
- Result slot:
  - res_valid clears on res_valid&&res_ready.
  - A new issue is blocked while res_valid=1, so a result is never overwritten.
- Latency:
  - Accept at cycle t; earliest mul_start at t+2.
  - res_valid at (multiplier done)+1.
- Width rule: res_product is the full 2*l_word signed product as delivered; no truncation or extension in this block.

Optional Feature:
- Macro: BOOTH_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the FIFO head has word1==0 or word2==0, pop it, set res_product=0, set res_valid=1 next cycle, and issue nothing (mul_start stays 0).
  - Bypass still waits for res_valid=0.
  - Bypass does not require mul_ready=1.
- Undefined: zero-operand pairs are issued normally.

Decomposition:
- Package booth_pkg:
  - FSM state encoding constants (IDLE, ISSUE, WAIT_ACK, WAIT_DONE).
  - Default l_word.
  - Product-width helper constant 2*l_word.
- Sub-module booth_operand_fifo:
  - Parameterised by width=2*l_word and DEPTH.
  - Ports: push, pop, data in/out, full, empty.

Test Plan (l_word=4, behavioural multiplier model with 3-10 cycle latency):
- Single op: word1=4'h3, word2=4'h5 -> one mul_start pulse; res_product=8'h0F; res_valid=1 until res_ready.
- Signed op: 4'hD (-3) x 4'h2 -> res_product=8'hFA; 4'h8 x 4'h8 -> 8'h40.
- Fill FIFO: push 5 pairs back-to-back with res_ready=0 and DEPTH=4 -> in_ready=0 after 4 accepted; accepted pairs drain in order with no drop; exactly one op in flight.
- Backpressure: hold res_ready=0 for 20 cycles -> no second mul_start; res_product stable; release gives in-order results.
- Reset mid-op: assert reset during WAIT_DONE -> next cycle res_valid=0, busy=0, in_ready=1; the late multiplier ready produces no result.
- With BOOTH_ZERO_BYPASS_EN: pair (4'h0, 4'h7) -> res_product=0 one cycle after reaching the head, with no mul_start pulse.
